// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide, with registered results, flags and a done pulse.
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             sign_flag,
  output logic             ovf_flag,
  output logic             dbz_flag
);

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpAnd  = 4'b0001;
  localparam logic [3:0] OpXor  = 4'b0010;
  localparam logic [3:0] OpComp = 4'b0011;
  localparam logic [3:0] OpShll = 4'b0100;
  localparam logic [3:0] OpShrl = 4'b0101;
  localparam logic [3:0] OpShra = 4'b0110;
  localparam logic [3:0] OpPass = 4'b0111;
  localparam logic [3:0] OpAdc  = 4'b1000;
  localparam logic [3:0] OpSub  = 4'b1001;
  localparam logic [3:0] OpMul  = 4'b1010;
  localparam logic [3:0] OpDiv  = 4'b1011;

  localparam logic [WIDTH-1:0] WidthW = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] OneW   = WIDTH'(1);
  localparam logic [SHW-1:0]   CntMax = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0]   CntOne = SHW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] out_q, out_d, out_hi_q, out_hi_d;
  logic             carry_q, carry_d, zero_q, zero_d, sign_q, sign_d;
  logic             ovf_q, ovf_d, dbz_q, dbz_d, done_q, done_d;

  // Shared adder for ADD/ADC/SUB
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic             add_ovf;
  logic             is_arith;

  always_comb begin
    add_b   = inp2;
    add_cin = 1'b0;
    if (op == OpAdc) begin
      add_cin = carry_q;
    end else if (op == OpSub) begin
      add_b   = ~inp2;
      add_cin = 1'b1;
    end
  end

  assign add_sum  = {1'b0, inp1} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  assign add_ovf  = (inp1[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != inp1[WIDTH-1]);
  assign is_arith = (op == OpAdd) || (op == OpAdc) || (op == OpSub);

  logic             sh_big;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;

  assign sh_big = (inp2 >= WidthW);
  assign shamt  = inp2[SHW-1:0];

  always_comb begin
    sc_res = '0;
    case (op)
      OpAdd, OpAdc, OpSub: sc_res = add_sum[WIDTH-1:0];
      OpAnd:  sc_res = inp1 & inp2;
      OpXor:  sc_res = inp1 ^ inp2;
      OpComp: sc_res = ~inp2 + OneW;
      OpShll: sc_res = sh_big ? '0 : (inp1 << shamt);
      OpShrl: sc_res = sh_big ? '0 : (inp1 >> shamt);
      OpShra: sc_res = sh_big ? {WIDTH{inp1[WIDTH-1]}} : $unsigned($signed(inp1) >>> shamt);
      OpPass: sc_res = inp1;
      default: sc_res = '0;
    endcase
  end

  // One iteration step: hi/lo hold {partial product, multiplier} or {remainder, quotient}
  logic [WIDTH:0]   mul_sum, div_sh, div_try;
  logic [WIDTH-1:0] hi_n, lo_n;

  assign mul_sum = {1'b0, hi_q} + {1'b0, dvs_q};
  assign div_sh  = {hi_q, lo_q[WIDTH-1]};
  assign div_try = div_sh - {1'b0, dvs_q};

  always_comb begin
    hi_n = hi_q;
    lo_n = lo_q;
    if (is_div_q) begin
      if (!div_try[WIDTH]) begin
        hi_n = div_try[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = div_sh[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else if (lo_q[0]) begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_n = {1'b0, hi_q[WIDTH-1:1]};
      lo_n = {hi_q[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if ((op == OpDiv) && (inp2 == '0)) begin
            out_d    = '1;
            out_hi_d = inp1;
            zero_d   = 1'b0;
            sign_d   = 1'b1;
            ovf_d    = 1'b0;
            dbz_d    = 1'b1;
            done_d   = 1'b1;
          end else if ((op == OpMul) || (op == OpDiv)) begin
            hi_d     = '0;
            lo_d     = inp1;
            dvs_d    = inp2;
            cnt_d    = '0;
            is_div_d = (op == OpDiv);
            state_d  = StIter;
          end else if (op[3:2] == 2'b11) begin
            // Illegal opcode: zero result, flags untouched
            out_d    = '0;
            out_hi_d = '0;
            done_d   = 1'b1;
          end else begin
            out_d    = sc_res;
            out_hi_d = '0;
            zero_d   = (sc_res == '0);
            sign_d   = sc_res[WIDTH-1];
            dbz_d    = 1'b0;
            ovf_d    = is_arith ? add_ovf : 1'b0;
            done_d   = 1'b1;
            if (is_arith) carry_d = add_sum[WIDTH];
          end
        end
      end
      StIter: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q + CntOne;
        if (cnt_q == CntMax) begin
          out_d    = lo_n;
          out_hi_d = hi_n;
          zero_d   = is_div_q ? (lo_n == '0) : ({hi_n, lo_n} == '0);
          sign_d   = lo_n[WIDTH-1];
          ovf_d    = 1'b0;
          dbz_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      hi_q     <= '0;
      lo_q     <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      out_q    <= '0;
      out_hi_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  assign busy       = (state_q == StIter);
  assign done       = done_q;
  assign out        = out_q;
  assign out_hi     = out_hi_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign sign_flag  = sign_q;
  assign ovf_flag   = ovf_q;
  assign dbz_flag   = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=32 and WIDTH=8; expected responses are queued
// at issue time and checked by per-instance monitors on each done pulse.
module tb_seq_alu;

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpAnd  = 4'b0001;
  localparam logic [3:0] OpXor  = 4'b0010;
  localparam logic [3:0] OpComp = 4'b0011;
  localparam logic [3:0] OpShll = 4'b0100;
  localparam logic [3:0] OpShrl = 4'b0101;
  localparam logic [3:0] OpShra = 4'b0110;
  localparam logic [3:0] OpPass = 4'b0111;
  localparam logic [3:0] OpAdc  = 4'b1000;
  localparam logic [3:0] OpSub  = 4'b1001;
  localparam logic [3:0] OpMul  = 4'b1010;
  localparam logic [3:0] OpDiv  = 4'b1011;

  // flags packed as {carry, zero, sign, ovf, dbz}
  typedef struct {
    string       nm;
    logic [31:0] o;
    logic [31:0] h;
    logic [4:0]  f;
    int          lat;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        start32, busy32, done32, c32, z32, s32, o32, d32;
  logic [3:0]  op32;
  logic [31:0] a32, b32, out32, hi32;
  logic        start8, busy8, done8, c8, z8, s8, o8, d8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, out8, hi8;

  exp_t q32[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .inp1(a32), .inp2(b32),
    .busy(busy32), .done(done32), .out(out32), .out_hi(hi32), .carry_flag(c32),
    .zero_flag(z32), .sign_flag(s32), .ovf_flag(o32), .dbz_flag(d32)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .inp1(a8), .inp2(b8),
    .busy(busy8), .done(done8), .out(out8), .out_hi(hi8), .carry_flag(c8),
    .zero_flag(z8), .sign_flag(s8), .ovf_flag(o8), .dbz_flag(d8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input string nm, input logic [31:0] o, input logic [31:0] h,
                              input logic [4:0] f, input int lat);
    exp_t e;
    e.nm  = nm;
    e.o   = o;
    e.h   = h;
    e.f   = f;
    e.lat = lat;
    e.t0  = 0;
    return e;
  endfunction

  // Called #1 after a rising edge; the request is sampled on the next edge.
  task automatic drive32(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e);
    exp_t x;
    x = e;
    start32 = 1'b1; op32 = o; a32 = a; b32 = b;
    x.t0 = cyc;
    q32.push_back(x);
    @(posedge clk); #1;
    start32 = 1'b0;
  endtask

  task automatic drive8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        input exp_t e);
    exp_t x;
    x = e;
    start8 = 1'b1; op8 = o; a8 = a; b8 = b;
    x.t0 = cyc;
    q8.push_back(x);
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic drain32(input int budget);
    int n;
    n = 0;
    while (q32.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain32_pending", q32.size(), 0);
    q32.delete();
  endtask

  task automatic drain8(input int budget);
    int n;
    n = 0;
    while (q8.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain8_pending", q8.size(), 0);
    q8.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done32) begin
      if (q32.size() == 0) begin
        chk("unexpected_done32", 1, 0);
      end else begin
        e = q32.pop_front();
        chk({e.nm, "_out"}, out32, e.o);
        chk({e.nm, "_hi"}, hi32, e.h);
        chk({e.nm, "_flags"}, {27'd0, c32, z32, s32, o32, d32}, {27'd0, e.f});
        chk({e.nm, "_lat"}, cyc - e.t0, e.lat);
        chk({e.nm, "_busy"}, {31'd0, busy32}, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done8) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 1, 0);
      end else begin
        e = q8.pop_front();
        chk({e.nm, "_out"}, {24'd0, out8}, e.o);
        chk({e.nm, "_hi"}, {24'd0, hi8}, e.h);
        chk({e.nm, "_flags"}, {27'd0, c8, z8, s8, o8, d8}, {27'd0, e.f});
        chk({e.nm, "_lat"}, cyc - e.t0, e.lat);
      end
    end
  end

  initial begin
    int nbusy;
    reset = 1'b1;
    start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst32_out", out32, 0);
    chk("rst32_hi", hi32, 0);
    chk("rst32_ctl", {25'd0, busy32, done32, c32, z32, s32, o32, d32}, 0);
    chk("rst8_outs", {8'd0, out8, hi8, 1'b0, busy8, done8, c8, z8, s8, o8, d8}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // WIDTH=32 arithmetic and carry chain
    drive32(OpAdd, 32'hFFFF_FFFF, 32'h1, mk("add32_wrap", 32'h0, 32'h0, 5'b11000, 1));
    drain32(5);
    drive32(OpAdc, 32'h0, 32'h0, mk("adc32_cin", 32'h1, 32'h0, 5'b00000, 1));
    drain32(5);
    drive32(OpSub, 32'h8000_0000, 32'h1, mk("sub32_ovf", 32'h7FFF_FFFF, 32'h0, 5'b10010, 1));
    drain32(5);
    drive32(OpShra, 32'h8000_0000, 32'd40, mk("shra32_big", 32'hFFFF_FFFF, 32'h0, 5'b10100, 1));
    drain32(5);

    // MUL with a start pulse and operand change while busy
    drive32(OpMul, 32'hFFFF_FFFF, 32'h2, mk("mul32", 32'hFFFF_FFFE, 32'h1, 5'b10100, 33));
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy32) nbusy++;
      if (i == 5) begin
        start32 = 1'b1; op32 = OpAdd; a32 = '0; b32 = '0;
      end else begin
        start32 = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("mul32_busy_cycles", nbusy, 32);
    drain32(5);

    drive32(OpDiv, 32'd100, 32'd7, mk("div32", 32'd14, 32'd2, 5'b10000, 33));
    drain32(40);
    drive32(OpDiv, 32'd5, 32'd0, mk("div32_dbz", 32'hFFFF_FFFF, 32'd5, 5'b10101, 1));
    drain32(5);
    drive32(4'b1100, 32'd123, 32'd456, mk("ill32_c", 32'h0, 32'h0, 5'b10101, 1));
    drain32(5);

    // Back-to-back single-cycle ops, one per cycle
    drive32(OpAnd, 32'hF0F0_00FF, 32'h0FF0_0F0F, mk("and32", 32'h00F0_000F, 0, 5'b10000, 1));
    drive32(OpXor, 32'hAAAA_AAAA, 32'hAAAA_AAAA, mk("xor32", 32'h0, 0, 5'b11000, 1));
    drive32(OpComp, 32'h55, 32'h1, mk("comp32", 32'hFFFF_FFFF, 0, 5'b10100, 1));
    drive32(OpShll, 32'h1, 32'd31, mk("shll32_31", 32'h8000_0000, 0, 5'b10100, 1));
    drive32(OpShrl, 32'h8000_0000, 32'd32, mk("shrl32_big", 32'h0, 0, 5'b11000, 1));
    drive32(OpShll, 32'h1234_5678, 32'd0, mk("shll32_0", 32'h1234_5678, 0, 5'b10000, 1));
    drive32(OpPass, 32'hDEAD_BEEF, 32'h0, mk("pass32", 32'hDEAD_BEEF, 0, 5'b10100, 1));
    drive32(OpShra, 32'h8000_0000, 32'd4, mk("shra32_4", 32'hF800_0000, 0, 5'b10100, 1));
    drive32(OpShrl, 32'h8000_0000, 32'd4, mk("shrl32_4", 32'h0800_0000, 0, 5'b10000, 1));
    drive32(OpAdc, 32'h1, 32'h1, mk("adc32_c1", 32'h3, 0, 5'b00000, 1));
    drive32(OpAdd, 32'h7FFF_FFFF, 32'h1, mk("add32_ovf", 32'h8000_0000, 0, 5'b00110, 1));
    drive32(4'b1110, 32'h1, 32'h1, mk("ill32_o", 32'h0, 0, 5'b00110, 1));
    drain32(10);
    drive32(OpMul, 32'h0, 32'd5, mk("mul32_zero", 32'h0, 32'h0, 5'b01000, 33));
    drain32(40);
    drive32(OpSub, 32'd5, 32'd5, mk("sub32_eq", 32'h0, 32'h0, 5'b11000, 1));
    drain32(5);

    // Reset during a MUL aborts it with no done pulse
    drive32(OpMul, 32'd3, 32'd5, mk("mul32_aborted", 32'd15, 32'd0, 5'b00000, 33));
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst32_out", out32, 0);
    chk("midrst32_hi", hi32, 0);
    chk("midrst32_ctl", {25'd0, busy32, done32, c32, z32, s32, o32, d32}, 0);
    q32.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    drive32(OpAdd, 32'd2, 32'd3, mk("add32_post", 32'd5, 32'd0, 5'b00000, 1));
    drain32(5);

    // WIDTH=8 instance
    drive8(OpAdd, 8'hFF, 8'h01, mk("add8_wrap", 32'h00, 32'h0, 5'b11000, 1));
    drain8(5);
    drive8(OpMul, 8'h10, 8'h10, mk("mul8", 32'h00, 32'h01, 5'b10000, 9));
    drain8(20);
    drive8(OpDiv, 8'd200, 8'd13, mk("div8", 32'd15, 32'd5, 5'b10000, 9));
    drain8(20);
    drive8(OpShra, 8'h80, 8'd8, mk("shra8_big", 32'hFF, 0, 5'b10100, 1));
    drive8(OpShrl, 8'h80, 8'd3, mk("shrl8_3", 32'h10, 0, 5'b10000, 1));
    drive8(OpSub, 8'h00, 8'h01, mk("sub8_borrow", 32'hFF, 0, 5'b00100, 1));
    drive8(OpAdd, 8'hFF, 8'hFF, mk("add8_neg", 32'hFE, 0, 5'b10100, 1));
    drive8(OpAdc, 8'h01, 8'h01, mk("adc8_c1", 32'h03, 0, 5'b00000, 1));
    drive8(OpDiv, 8'd9, 8'd0, mk("div8_dbz", 32'hFF, 32'h09, 5'b00101, 1));
    drain8(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Adds a start/done handshake, registered results and flags, and an add-with-carry chain that uses the stored carry.
- Adds overflow detection, an iterative unsigned multiply (shift-add) and an iterative unsigned divide (restoring).
- Sits in the execute stage; the control FSM issues one operation at a time and stalls on busy.

Parameters:
- WIDTH, 32: operand/result width in bits; must be ≥ 4.
- SHW, $clog2(WIDTH): width of the effective shift amount.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  operation request; sampled only in IDLE.
- op  input  4  opcode.
- inp1  input  WIDTH  operand A (rs).
- inp2  input  WIDTH  operand B (rt / shift amount).
- busy  output  1  high while MUL/DIV is iterating.
- done  output  1  one-cycle pulse; out/out_hi valid in the same cycle.
- out  output  WIDTH  result: low product for MUL, quotient for DIV.
- out_hi  output  WIDTH  high product for MUL, remainder for DIV, 0 otherwise.
- carry_flag  output  1  registered carry.
- zero_flag  output  1  registered: out == 0.
- sign_flag  output  1  registered: out[WIDTH-1].
- ovf_flag  output  1  registered signed overflow.
- dbz_flag  output  1  registered divide-by-zero.

Behaviour:
- Reset is asynchronous, active-high; clock is clk. On reset all outputs are 0 and the state is IDLE. Reset mid-MUL/DIV aborts with no done pulse.
- Opcodes:
  - 0000 ADD: A+B.
  - 0001 AND.
  - 0010 XOR.
  - 0011 COMP: ~B+1.
  - 0100 SHLL.
  - 0101 SHRL.
  - 0110 SHRA.
  - 0111 PASS: A.
  - 1000 ADC: A+B+carry_flag.
  - 1001 SUB: A+~B+1.
  - 1010 MUL: unsigned, 2·WIDTH-bit result.
  - 1011 DIVU: unsigned.
  - 1100–1111: illegal.
- States: IDLE, ITER, DONE.
- Single-cycle ops (0000–1001, illegal): start sampled high in IDLE at edge t → out/flags/done registered at edge t+1. done is high for exactly one cycle and busy stays 0. The FSM returns to IDLE, so back-to-back starts are accepted every cycle.
- MUL/DIVU: start at edge t → ITER.
  - busy is high from t+1 through t+WIDTH (WIDTH iterations, one bit per cycle).
  - Result, flags and done are registered at t+WIDTH+1; busy drops at the same edge.
- start is ignored while busy. op, inp1 and inp2 are captured at start; later changes have no effect.
- out/out_hi hold their last values between operations. done is 0 except for the completion pulse.
- Carry:
  - ADD/ADC/SUB write carry_flag = carry out of bit WIDTH-1. For SUB, 1 means no borrow.
  - All other ops leave carry_flag unchanged.
  - ADC at reset uses carry_flag = 0.
- Overflow: ADD/ADC/SUB write ovf_flag = signed overflow (operand signs equal and result sign differs; for SUB, use ~B). Other legal ops clear ovf_flag.
- zero_flag and sign_flag are written by every legal op from out; for MUL, zero_flag = ({out_hi,out} == 0).
- Shifts:
  - Amount is inp2 interpreted unsigned.
  - Amount ≥ WIDTH gives 0 for SHLL/SHRL, and all copies of A[WIDTH-1] for SHRA.
  - Amount 0 gives A.
- DIVU by zero: no iteration. Done fires at t+1 with out = all ones, out_hi = A, dbz_flag = 1. Any other legal op clears dbz_flag.
- Illegal op: done fires at t+1 with out = 0 and out_hi = 0; all flags are unchanged.
- A start in the same cycle as the done pulse is accepted, because the FSM is in IDLE that cycle for single-cycle ops. For MUL/DIV, a start is accepted on the cycle after done.

Test Plan:
- Reset, then ADD A=0xFFFFFFFF B=0x00000001 → done at t+1; out=0, carry=1, zero=1, ovf=0. Then ADC A=0 B=0 → out=1, carry=0.
- SUB A=0x80000000 B=0x00000001 → out=0x7FFFFFFF, ovf=1, carry=1, sign=0. SHRA A=0x80000000 B=40 → out=0xFFFFFFFF.
- MUL A=0xFFFFFFFF B=0x00000002 (WIDTH=32) → busy for 32 cycles, done at t+33; out_hi=0x00000001, out=0xFFFFFFFE, zero=0. A start pulsed mid-busy is ignored, and carry is unchanged.
- DIVU A=100 B=7 → done at t+33, out=14, out_hi=2, dbz=0. DIVU A=5 B=0 → done at t+1, out=0xFFFFFFFF, out_hi=5, dbz=1.
- Assert reset at cycle 10 of a MUL → all outputs 0 immediately, no done pulse. A following ADD 2+3 → out=5 at t+1.
- Repeat ADD and MUL with WIDTH=8: 0xFF+0x01 → carry=1. MUL 0x10×0x10 → out_hi=0x01, out=0x00, done at t+9.
